// File: rtl/hwc_pkg.sv
// hwc_pkg: shared definitions for the hardwired controller.
//   mode_e       console mode encodings for {swc,swb,swa}
//   OP_*         instruction opcodes (ir[IR_W-1 -: 4])
//   ALU_*        ALU function codes driven on s
//   ctrl_word_t  one decoded control word (datapath strobes plus the
//                beat-control bits short_cyc/long_cyc and the st0 set request)
//   sel_width()  register-select width for a register file of nreg entries
//   pair_width() width of the register-pair index (nreg/2 pairs)
package hwc_pkg;

  typedef enum logic [2:0] {
    MODE_EXEC   = 3'b000,
    MODE_MEM_WR = 3'b001,
    MODE_MEM_RD = 3'b010,
    MODE_REG_RD = 3'b011,
    MODE_REG_WR = 3'b100
  } mode_e;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_INC = 4'b0100;
  localparam logic [3:0] OP_LD  = 4'b0101;
  localparam logic [3:0] OP_ST  = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_JMP = 4'b1001;
  localparam logic [3:0] OP_DI  = 4'b1010;
  localparam logic [3:0] OP_EI  = 4'b1011;
  localparam logic [3:0] OP_STP = 4'b1110;

  localparam logic [3:0] ALU_ADD    = 4'b1001;
  localparam logic [3:0] ALU_SUB    = 4'b0110;
  localparam logic [3:0] ALU_AND    = 4'b1011;
  localparam logic [3:0] ALU_INC    = 4'b0000;
  localparam logic [3:0] ALU_PASS_A = 4'b1111;
  localparam logic [3:0] ALU_PASS_B = 4'b1010;

  typedef struct packed {
    logic [3:0] s;
    logic       m;
    logic       cin;
    logic       drw;
    logic       pcinc;
    logic       lpc;
    logic       lar;
    logic       pcadd;
    logic       arinc;
    logic       selctl;
    logic       memw;
    logic       stop;
    logic       lir;
    logic       ldz;
    logic       ldc;
    logic       abus;
    logic       sbus;
    logic       mbus;
    logic       short_cyc;
    logic       long_cyc;
    logic       sst0;
  } ctrl_word_t;

  function automatic int sel_width(input int nreg);
    return 2 * $clog2(nreg);
  endfunction

  function automatic int pair_width(input int nreg);
    return $clog2(nreg) - 1;
  endfunction

endpackage

// File: rtl/hwc_beat_gen.sv
// hwc_beat_gen: one-hot beat counter W1..W(MAX_BEATS).
//   clk       beat clock (rising edge)
//   clr       synchronous active-low reset, forces W1
//   restart   force W1 at the next edge (mode change / interrupt beat)
//   short_cyc at W1: repeat W1; at W2: return to W1 instead of W3
//   long_cyc  at W3 and later: advance instead of returning to W1
//   w         one-hot current beat, w[0] = W1
//   cycle_end the current beat is the last one of this machine cycle
module hwc_beat_gen #(
  parameter int MAX_BEATS = 3
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 restart,
  input  logic                 short_cyc,
  input  logic                 long_cyc,
  output logic [MAX_BEATS-1:0] w,
  output logic                 cycle_end
);

  always_comb begin
    cycle_end = 1'b0;
    if (w[0] || w[1]) begin
      cycle_end = short_cyc;
    end else begin
      // the last beat always wraps, even if long is still requested
      cycle_end = !long_cyc || w[MAX_BEATS-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!clr || restart || cycle_end) begin
      w <= MAX_BEATS'(1);
    end else begin
      w <= w << 1;
    end
  end

endmodule

// File: rtl/hw_ctrl_seq.sv
// hw_ctrl_seq: hardwired controller for the teaching CPU. Generates the
// beat sequence and console state bit st0, and decodes console mode plus
// IR opcode into the datapath control word.
//   t3, clr          clock (rising edge), synchronous active-low reset
//   sw               console mode {swc,swb,swa}
//   ir               instruction register, opcode = ir[IR_W-1 -: 4]
//   c, z             ALU carry / zero flags
//   w                one-hot current beat; st0 console/exec phase bit
//   s, m, cin        ALU function controls
//   sel              {dest, src} register select; register writes drive src=0
//   drw .. long_o    single-bit datapath strobes and cycle-length flags
// Optional feature macro HWC_INT_EN: adds int_req (in) / int_ack (out), an
// interrupt-enable flag and the DI/EI opcodes; otherwise DI/EI are NOPs.
module hw_ctrl_seq
  import hwc_pkg::*;
#(
  parameter  int NREG      = 4,
  parameter  int MAX_BEATS = 3,
  parameter  int IR_W      = 4,
  localparam int SEL_W     = sel_width(NREG)
) (
  input  logic                 t3,
  input  logic                 clr,
  input  logic [2:0]           sw,
  input  logic [IR_W-1:0]      ir,
  input  logic                 c,
  input  logic                 z,
`ifdef HWC_INT_EN
  input  logic                 int_req,
  output logic                 int_ack,
`endif
  output logic [MAX_BEATS-1:0] w,
  output logic                 st0,
  output logic [3:0]           s,
  output logic                 m,
  output logic                 cin,
  output logic [SEL_W-1:0]     sel,
  output logic                 drw,
  output logic                 pcinc,
  output logic                 lpc,
  output logic                 lar,
  output logic                 pcadd,
  output logic                 arinc,
  output logic                 selctl,
  output logic                 memw,
  output logic                 stop,
  output logic                 lir,
  output logic                 ldz,
  output logic                 ldc,
  output logic                 abus,
  output logic                 sbus,
  output logic                 mbus,
  output logic                 short_o,
  output logic                 long_o
);

  localparam int                PAIR_W    = pair_width(NREG);
  localparam int                REG_W     = $clog2(NREG);
  localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(NREG / 2 - 1);

  logic [2:0]        mode_q;
  logic [PAIR_W-1:0] reg_idx;
  logic [3:0]        op;
  logic              mode_chg;
  logic              cycle_end;
  logic              st0_clr;
  logic              idx_inc;
  logic              en;
  logic              int_st;
  logic              go_int;
  ctrl_word_t        cw;
  logic [SEL_W-1:0]  sel_raw;

  assign op       = ir[IR_W-1 -: 4];
  assign mode_chg = (sw != mode_q);

`ifdef HWC_INT_EN
  logic ie;
  logic ie_set;
  logic ie_clr;

  // Interrupt taken on the last beat of an executing instruction; it wins
  // over a simultaneous mode change.
  assign go_int = int_req && ie && !int_st && (mode_q == MODE_EXEC) && st0 && cycle_end;

  always_ff @(posedge t3) begin
    if (!clr) begin
      ie     <= 1'b1;
      int_st <= 1'b0;
    end else if (int_st) begin
      int_st <= 1'b0;
      ie     <= 1'b0;
    end else if (go_int) begin
      int_st <= 1'b1;
    end else if (!mode_chg) begin
      if (ie_clr) begin
        ie <= 1'b0;
      end else if (ie_set) begin
        ie <= 1'b1;
      end
    end
  end

  assign int_ack = clr && int_st;
`else
  assign go_int = 1'b0;
  assign int_st = 1'b0;
`endif

  hwc_beat_gen #(
    .MAX_BEATS (MAX_BEATS)
  ) u_beat (
    .clk       (t3),
    .clr       (clr),
    .restart   (mode_chg || int_st),
    .short_cyc (cw.short_cyc),
    .long_cyc  (cw.long_cyc),
    .w         (w),
    .cycle_end (cycle_end)
  );

  always_comb begin
    cw      = '0;
    sel_raw = '0;
    st0_clr = 1'b0;
    idx_inc = 1'b0;
`ifdef HWC_INT_EN
    ie_set  = 1'b0;
    ie_clr  = 1'b0;
`endif
    case (mode_q)
      MODE_REG_WR: begin
        if (w[0] || w[1]) begin
          cw.sbus   = 1'b1;
          cw.drw    = 1'b1;
          cw.selctl = 1'b1;
          cw.stop   = 1'b1;
          // W1 writes the even register of the pair, W2 the odd one
          sel_raw   = {reg_idx, w[1], REG_W'(0)};
        end
        if (w[1]) begin
          cw.short_cyc = 1'b1;
          idx_inc      = 1'b1;
          cw.sst0      = !st0 && (reg_idx == '0);
          st0_clr      = st0 && (reg_idx == LAST_PAIR);
        end
      end
      MODE_REG_RD: begin
        if (w[0] || w[1]) begin
          cw.selctl    = 1'b1;
          cw.stop      = 1'b1;
          cw.short_cyc = w[1];
          idx_inc      = 1'b1;
          sel_raw      = {reg_idx, 1'b0, reg_idx, 1'b1};
        end
      end
      MODE_MEM_RD, MODE_MEM_WR: begin
        if (w[0]) begin
          cw.short_cyc = 1'b1;
          cw.stop      = 1'b1;
          if (!st0) begin
            cw.sbus = 1'b1;
            cw.lar  = 1'b1;
            cw.sst0 = 1'b1;
          end else begin
            cw.arinc = 1'b1;
            if (mode_q == MODE_MEM_RD) begin
              cw.mbus = 1'b1;
            end else begin
              cw.sbus = 1'b1;
              cw.memw = 1'b1;
            end
          end
        end
      end
      MODE_EXEC: begin
        if (!st0) begin
          if (w[0]) begin
            cw.sbus      = 1'b1;
            cw.lpc       = 1'b1;
            cw.short_cyc = 1'b1;
            cw.stop      = 1'b1;
            cw.sst0      = 1'b1;
          end
        end else if (w[0]) begin
          cw.lir   = 1'b1;
          cw.pcinc = 1'b1;
        end else if (w[1]) begin
          cw.short_cyc = 1'b1;
          case (op)
            OP_ADD: begin
              cw.s = ALU_ADD; cw.cin = 1'b1;
              cw.abus = 1'b1; cw.drw = 1'b1; cw.ldz = 1'b1; cw.ldc = 1'b1;
            end
            OP_SUB: begin
              cw.s = ALU_SUB;
              cw.abus = 1'b1; cw.drw = 1'b1; cw.ldz = 1'b1; cw.ldc = 1'b1;
            end
            OP_AND: begin
              cw.s = ALU_AND; cw.m = 1'b1;
              cw.abus = 1'b1; cw.drw = 1'b1; cw.ldz = 1'b1;
            end
            OP_INC: begin
              cw.s = ALU_INC;
              cw.abus = 1'b1; cw.drw = 1'b1; cw.ldz = 1'b1; cw.ldc = 1'b1;
            end
            OP_LD, OP_ST: begin
              // address phase; the memory access follows in W3
              cw.s = (op == OP_LD) ? ALU_PASS_B : ALU_PASS_A; cw.m = 1'b1;
              cw.abus = 1'b1; cw.lar = 1'b1;
              cw.short_cyc = 1'b0; cw.long_cyc = 1'b1;
            end
            OP_JC:  cw.pcadd = c;
            OP_JZ:  cw.pcadd = z;
            OP_JMP: begin
              cw.s = ALU_PASS_A; cw.m = 1'b1;
              cw.abus = 1'b1; cw.lpc = 1'b1;
            end
            OP_STP: cw.stop = 1'b1;
`ifdef HWC_INT_EN
            OP_DI:  ie_clr = 1'b1;
            OP_EI:  ie_set = 1'b1;
`endif
            default: ;
          endcase
        end else if (w[2]) begin
          case (op)
            OP_LD: begin
              cw.mbus = 1'b1; cw.drw = 1'b1;
            end
            OP_ST: begin
              cw.s = ALU_PASS_B; cw.m = 1'b1;
              cw.abus = 1'b1; cw.memw = 1'b1;
            end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  // Strobes are silent in reset, in a mode-change cycle and in the INT beat.
  assign en      = clr && !mode_chg && !int_st;
  assign s       = {4{en}} & cw.s;
  assign m       = en & cw.m;
  assign cin     = en & cw.cin;
  assign sel     = {SEL_W{en}} & sel_raw;
  assign drw     = en & cw.drw;
  assign pcinc   = en & cw.pcinc;
  assign lpc     = en & cw.lpc;
  assign lar     = en & cw.lar;
  assign pcadd   = en & cw.pcadd;
  assign arinc   = en & cw.arinc;
  assign selctl  = en & cw.selctl;
  assign memw    = en & cw.memw;
  assign stop    = (en & cw.stop) | (clr & int_st);
  assign lir     = en & cw.lir;
  assign ldz     = en & cw.ldz;
  assign ldc     = en & cw.ldc;
  assign abus    = en & cw.abus;
  assign sbus    = en & cw.sbus;
  assign mbus    = en & cw.mbus;
  assign short_o = en & cw.short_cyc;
  assign long_o  = en & cw.long_cyc;

  always_ff @(posedge t3) begin
    if (!clr) begin
      st0     <= 1'b0;
      reg_idx <= '0;
      mode_q  <= sw;
    end else if (mode_chg && !go_int) begin
      st0     <= 1'b0;
      reg_idx <= '0;
      mode_q  <= sw;
    end else if (!mode_chg && !int_st) begin
      if (cw.sst0) begin
        st0 <= 1'b1;
      end else if (st0_clr) begin
        st0 <= 1'b0;
      end
      if (idx_inc) begin
        reg_idx <= reg_idx + PAIR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hw_ctrl_seq.sv
module tb_hw_ctrl_seq;

  localparam int NREG      = 4;
  localparam int MAX_BEATS = 3;
  localparam int IR_W      = 4;
  localparam int SEL_W     = 4;

  logic                 t3 = 1'b0;
  logic                 clr;
  logic [2:0]           sw;
  logic [IR_W-1:0]      ir;
  logic                 c;
  logic                 z;
  logic [MAX_BEATS-1:0] w;
  logic                 st0;
  logic [3:0]           s;
  logic                 m, cin;
  logic [SEL_W-1:0]     sel;
  logic drw, pcinc, lpc, lar, pcadd, arinc, selctl, memw, stop, lir;
  logic ldz, ldc, abus, sbus, mbus, short_o, long_o;
`ifdef HWC_INT_EN
  logic int_req;
  logic int_ack;
`endif

  int n_chk = 0;
  int n_err = 0;

  logic [26:0] allout;
  assign allout = {s, m, cin, sel, drw, pcinc, lpc, lar, pcadd, arinc, selctl,
                   memw, stop, lir, ldz, ldc, abus, sbus, mbus, short_o, long_o};

  hw_ctrl_seq #(
    .NREG      (NREG),
    .MAX_BEATS (MAX_BEATS),
    .IR_W      (IR_W)
  ) dut (
    .t3      (t3),
    .clr     (clr),
    .sw      (sw),
    .ir      (ir),
    .c       (c),
    .z       (z),
`ifdef HWC_INT_EN
    .int_req (int_req),
    .int_ack (int_ack),
`endif
    .w       (w),
    .st0     (st0),
    .s       (s),
    .m       (m),
    .cin     (cin),
    .sel     (sel),
    .drw     (drw),
    .pcinc   (pcinc),
    .lpc     (lpc),
    .lar     (lar),
    .pcadd   (pcadd),
    .arinc   (arinc),
    .selctl  (selctl),
    .memw    (memw),
    .stop    (stop),
    .lir     (lir),
    .ldz     (ldz),
    .ldc     (ldc),
    .abus    (abus),
    .sbus    (sbus),
    .mbus    (mbus),
    .short_o (short_o),
    .long_o  (long_o)
  );

  always #5 t3 = ~t3;

  task automatic tick();
    @(posedge t3);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    clr = 1'b0; sw = 3'b000; ir = '0; c = 1'b0; z = 1'b0;
`ifdef HWC_INT_EN
    int_req = 1'b0;
`endif
    // reset held over two edges
    tick(); tick();
    chk("rst_w", 32'(w), 32'h1);
    chk("rst_st0", 32'(st0), 32'h0);
    chk("rst_outs", 32'(allout), 32'h0);

    // register write, NREG=4: dest 0,1,2,3
    sw = 3'b100; tick(); clr = 1'b1; #1;
    chk("wr0_dest", 32'(sel[3:2]), 32'h0);
    chk("wr0_drw", 32'(drw), 32'h1);
    tick();
    chk("wr1_w", 32'(w), 32'h2);
    chk("wr1_dest", 32'(sel[3:2]), 32'h1);
    chk("wr1_drw", 32'(drw), 32'h1);
    tick();
    chk("wr_st0_set", 32'(st0), 32'h1);
    chk("wr2_dest", 32'(sel[3:2]), 32'h2);
    tick();
    chk("wr3_dest", 32'(sel[3:2]), 32'h3);
    chk("wr3_drw", 32'(drw), 32'h1);
    tick();
    chk("wr_st0_clr", 32'(st0), 32'h0);
    chk("wr_end_w", 32'(w), 32'h1);

    // memory write
    clr = 1'b0; sw = 3'b001; tick(); clr = 1'b1; #1;
    chk("mw_lar", 32'(lar), 32'h1);
    chk("mw_short0", 32'(short_o), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mw_st0", 32'(st0), 32'h1);
      chk("mw_strobes", 32'({memw, arinc, short_o}), 32'h7);
      chk("mw_w", 32'(w), 32'h1);
    end

    // execute mode
    clr = 1'b0; sw = 3'b000; tick(); clr = 1'b1; #1;
    chk("ex_lpc", 32'(lpc), 32'h1);
    tick();
    chk("ex_st0", 32'(st0), 32'h1);
    chk("fetch", 32'({lir, pcinc}), 32'h3);
    ir = 4'b0111; c = 1'b1;
    tick();
    chk("jc_w", 32'(w), 32'h2);
    chk("jc_c1", 32'(pcadd), 32'h1);
    chk("jc_short", 32'(short_o), 32'h1);
    tick(); c = 1'b0;
    tick();
    chk("jc_c0", 32'(pcadd), 32'h0);
    tick(); ir = 4'b1000; z = 1'b1;
    tick();
    chk("jz_z1", 32'(pcadd), 32'h1);
    tick(); ir = 4'b0101;
    tick();
    chk("ld_w2", 32'({lar, long_o, short_o}), 32'h6);
    tick();
    chk("ld_w3", 32'(w), 32'h4);
    chk("ld_mbus_drw", 32'({mbus, drw}), 32'h3);
    tick();
    chk("ld_back_w1", 32'(w), 32'h1);
    ir = 4'b0001;
    tick();
    chk("add_strobes", 32'({abus, drw, ldz, ldc}), 32'hF);
    chk("add_alu", 32'({s, m, cin}), 32'h25);
    tick(); ir = 4'b0011;
    tick();
    chk("and_flags", 32'({ldz, ldc, m}), 32'h5);
    tick(); ir = 4'b1110;
    tick();
    chk("stp_stop", 32'(stop), 32'h1);
`ifndef HWC_INT_EN
    tick(); ir = 4'b1010;
    tick();
    chk("op1010_nop", 32'(allout), 32'h2);
`endif

    // mode change while executing
    tick(); ir = 4'b1001;
    tick();
    chk("jmp_lpc", 32'(lpc), 32'h1);
    sw = 3'b011; #1;
    chk("mchg_quiet", 32'(allout), 32'h0);
    tick();
    chk("mchg_w", 32'(w), 32'h1);
    chk("mchg_st0", 32'(st0), 32'h0);
    chk("rd0_sel", 32'(sel), 32'h1);
    chk("rd0_selctl", 32'(selctl), 32'h1);
    tick();
    chk("rd1_sel", 32'(sel), 32'hB);
    tick();
    chk("rd_wrap_sel", 32'(sel), 32'h1);

`ifdef HWC_INT_EN
    clr = 1'b0; sw = 3'b000; ir = '0; tick(); clr = 1'b1;
    tick();
    ir = 4'b0001; int_req = 1'b1; #1;
    chk("int_fetch_ack", 32'(int_ack), 32'h0);
    tick();
    chk("int_add_ack", 32'(int_ack), 32'h0);
    tick();
    chk("int_ack", 32'(int_ack), 32'h1);
    chk("int_stop", 32'(stop), 32'h1);
    chk("int_w", 32'(w), 32'h1);
    int_req = 1'b0;
    tick();
    chk("int_done", 32'({int_ack, lir}), 32'h1);
    ir = 4'b1011;
    tick(); tick(); ir = 4'b1010;
    tick(); tick(); ir = 4'b0001; int_req = 1'b1;
    tick(); tick();
    chk("di_masks", 32'({int_ack, lir}), 32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
